// File: rtl/clic_irq_bridge.sv
`default_nettype none
// ============================================================================
// Module      : clic_irq_bridge
// Description : Core-side handshake controller for one CLIC target. Registers
//               the offered interrupt and presents it to the hart as a level
//               request with sideband fields. A hart ack whose id matches the
//               presented id completes the target handshake. A target kill
//               request withdraws the offer. An ack that does not complete a
//               handshake is reported on ack_err_o in the following cycle.
// Ports       : clk_i, rst_i (async, active-high)
//               irq_* : target offer, ready and kill handshake
//               irq_en_i : hart global enable, gates core_irq_o only
//               core_* : level request, sideband fields, hart ack
//               ack_err_o : one-cycle pulse on an invalid ack
// Revision    : 1.0 - initial release
// ============================================================================
module clic_irq_bridge #(
  parameter int unsigned SrcWidth  = 8,
  parameter int unsigned PrioWidth = 8,
  parameter int unsigned ModeWidth = 2,
  parameter int unsigned VsidWidth = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 irq_valid_i,
  output logic                 irq_ready_o,
  input  logic [SrcWidth-1:0]  irq_id_i,
  input  logic [PrioWidth-1:0] irq_max_i,
  input  logic [ModeWidth-1:0] irq_mode_i,
  input  logic [VsidWidth-1:0] irq_vsid_i,
  input  logic                 irq_v_i,
  input  logic                 irq_shv_i,
  input  logic                 irq_kill_req_i,
  output logic                 irq_kill_ack_o,
  input  logic                 irq_en_i,
  output logic                 core_irq_o,
  output logic [SrcWidth-1:0]  core_irq_id_o,
  output logic [PrioWidth-1:0] core_irq_level_o,
  output logic [ModeWidth-1:0] core_irq_mode_o,
  output logic [VsidWidth-1:0] core_irq_vsid_o,
  output logic                 core_irq_v_o,
  output logic                 core_irq_shv_o,
  input  logic                 core_ack_i,
  input  logic [SrcWidth-1:0]  core_ack_id_i,
  output logic                 ack_err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic                 w_latch;
  logic                 w_err_nxt;
  logic                 w_ready;
  logic                 w_kill_ack;
  logic                 w_ack_match;

  logic [SrcWidth-1:0]  r_id;
  logic [PrioWidth-1:0] r_level;
  logic [ModeWidth-1:0] r_mode;
  logic [VsidWidth-1:0] r_vsid;
  logic                 r_v;
  logic                 r_shv;
  logic                 r_ack_err;

  // The ack must name the id the hart was actually shown, not the id
  // currently on the target bus (which may have been retargeted this cycle).
  assign w_ack_match = core_ack_i && (core_ack_id_i == r_id);

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_err_nxt   = 1'b0;
    w_ready     = 1'b0;
    w_kill_ack  = 1'b0;
    case (r_state)
      IDLE: begin
        // Nothing is presented, so any ack here is spurious.
        w_err_nxt = core_ack_i;
        if (irq_valid_i) begin
          w_latch     = 1'b1;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        if (!irq_valid_i) begin
          // Offer withdrawn: an ack in the same cycle cannot complete.
          w_state_nxt = IDLE;
          w_err_nxt   = core_ack_i;
        end else if (w_ack_match) begin
          // Ack wins over a simultaneous kill request.
          w_ready     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_err_nxt = core_ack_i;
          if (irq_kill_req_i) begin
            w_kill_ack  = 1'b1;
            w_state_nxt = IDLE;
          end else if (!core_ack_i) begin
            // Quiet cycle: follow target retargeting.
            w_latch = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_ack_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack_err <= w_err_nxt;
    end
  end

  // Fields hold their last value in IDLE; they are only cleared by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_id    <= '0;
      r_level <= '0;
      r_mode  <= '0;
      r_vsid  <= '0;
      r_v     <= 1'b0;
      r_shv   <= 1'b0;
    end else if (w_latch) begin
      r_id    <= irq_id_i;
      r_level <= irq_max_i;
      r_mode  <= irq_mode_i;
      r_vsid  <= irq_vsid_i;
      r_v     <= irq_v_i;
      r_shv   <= irq_shv_i;
    end
  end

  // Derived from the state register so reset removes the request at once.
  assign core_irq_o       = (r_state == PEND) && irq_en_i;
  assign irq_ready_o      = w_ready;
  assign irq_kill_ack_o   = w_kill_ack;
  assign ack_err_o        = r_ack_err;
  assign core_irq_id_o    = r_id;
  assign core_irq_level_o = r_level;
  assign core_irq_mode_o  = r_mode;
  assign core_irq_vsid_o  = r_vsid;
  assign core_irq_v_o     = r_v;
  assign core_irq_shv_o   = r_shv;

endmodule
`default_nettype wire

// File: tb/tb_clic_irq_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_clic_irq_bridge
// Description : Self-checking bench for clic_irq_bridge: a directed vector
//               table, an asynchronous reset sequence, then random traffic
//               compared against an offer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clic_irq_bridge;

  logic       clk;
  logic       rst;
  logic       irq_valid;
  logic       irq_ready;
  logic [7:0] irq_id;
  logic [7:0] irq_max;
  logic [1:0] irq_mode;
  logic [5:0] irq_vsid;
  logic       irq_v;
  logic       irq_shv;
  logic       irq_kill_req;
  logic       irq_kill_ack;
  logic       irq_en;
  logic       core_irq;
  logic [7:0] core_irq_id;
  logic [7:0] core_irq_level;
  logic [1:0] core_irq_mode;
  logic [5:0] core_irq_vsid;
  logic       core_irq_v;
  logic       core_irq_shv;
  logic       core_ack;
  logic [7:0] core_ack_id;
  logic       ack_err;

  clic_irq_bridge #(
    .SrcWidth (8),
    .PrioWidth(8),
    .ModeWidth(2),
    .VsidWidth(6)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .irq_valid_i     (irq_valid),
    .irq_ready_o     (irq_ready),
    .irq_id_i        (irq_id),
    .irq_max_i       (irq_max),
    .irq_mode_i      (irq_mode),
    .irq_vsid_i      (irq_vsid),
    .irq_v_i         (irq_v),
    .irq_shv_i       (irq_shv),
    .irq_kill_req_i  (irq_kill_req),
    .irq_kill_ack_o  (irq_kill_ack),
    .irq_en_i        (irq_en),
    .core_irq_o      (core_irq),
    .core_irq_id_o   (core_irq_id),
    .core_irq_level_o(core_irq_level),
    .core_irq_mode_o (core_irq_mode),
    .core_irq_vsid_o (core_irq_vsid),
    .core_irq_v_o    (core_irq_v),
    .core_irq_shv_o  (core_irq_shv),
    .core_ack_i      (core_ack),
    .core_ack_id_i   (core_ack_id),
    .ack_err_o       (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed sideband values are derived from the id so a whole offer can be
  // checked from a single expected id (all derivations map 0 to 0).
  function automatic logic [7:0] lvl_of(input logic [7:0] id);
    return {id[3:0], id[7:4]};
  endfunction
  function automatic logic [1:0] mode_of(input logic [7:0] id);
    return id[1:0];
  endfunction
  function automatic logic [5:0] vsid_of(input logic [7:0] id);
    return id[7:2];
  endfunction
  function automatic logic v_of(input logic [7:0] id);
    return id[0];
  endfunction
  function automatic logic shv_of(input logic [7:0] id);
    return id[1] ^ id[2];
  endfunction

  // ---------------- reference model (offer level) ----------------
  typedef struct packed {
    logic [7:0] id;
    logic [7:0] lvl;
    logic [1:0] mode;
    logic [5:0] vsid;
    logic       v;
    logic       shv;
  } offer_t;

  bit     m_pend;
  offer_t m_shown;
  bit     m_err;

  function automatic offer_t bus_offer();
    offer_t o;
    o.id = irq_id; o.lvl = irq_max; o.mode = irq_mode;
    o.vsid = irq_vsid; o.v = irq_v; o.shv = irq_shv;
    return o;
  endfunction

  // A handshake completes only when the hart names the offer it was shown
  // while the target still offers it.
  function automatic bit exp_ready();
    return m_pend && irq_valid && core_ack && (core_ack_id == m_shown.id);
  endfunction
  function automatic bit exp_kill();
    return m_pend && irq_valid && !exp_ready() && irq_kill_req;
  endfunction

  task automatic model_reset();
    m_pend  = 0;
    m_shown = '0;
    m_err   = 0;
  endtask

  // Called just after a rising edge, with the inputs that were sampled there.
  task automatic model_step();
    bit r, k;
    r = exp_ready();
    k = exp_kill();
    m_err = core_ack && !r;  // every ack that completes nothing is an error
    if (!m_pend) begin
      if (irq_valid) begin
        m_pend  = 1;
        m_shown = bus_offer();
      end
    end else if (!irq_valid || r || k) begin
      m_pend = 0;
    end else if (!core_ack) begin
      m_shown = bus_offer();
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " core_irq"},  core_irq,       m_pend && irq_en);
    check({tag, " ready"},     irq_ready,      exp_ready());
    check({tag, " kill_ack"},  irq_kill_ack,   exp_kill());
    check({tag, " ack_err"},   ack_err,        m_err);
    check({tag, " id"},        core_irq_id,    m_shown.id);
    check({tag, " level"},     core_irq_level, m_shown.lvl);
    check({tag, " mode"},      core_irq_mode,  m_shown.mode);
    check({tag, " vsid"},      core_irq_vsid,  m_shown.vsid);
    check({tag, " v"},         core_irq_v,     m_shown.v);
    check({tag, " shv"},       core_irq_shv,   m_shown.shv);
  endtask

  task automatic drive(input logic valid, input logic [7:0] id, input logic en,
                       input logic kill, input logic ack, input logic [7:0] ack_id);
    irq_valid    = valid;
    irq_id       = id;
    irq_max      = lvl_of(id);
    irq_mode     = mode_of(id);
    irq_vsid     = vsid_of(id);
    irq_v        = v_of(id);
    irq_shv      = shv_of(id);
    irq_en       = en;
    irq_kill_req = kill;
    core_ack     = ack;
    core_ack_id  = ack_id;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       valid;
    logic [7:0] id;
    logic       en;
    logic       kill;
    logic       ack;
    logic [7:0] ack_id;
    logic       e_irq;
    logic [7:0] e_id;
    logic       e_ready;
    logic       e_kill;
    logic       e_err;
  } vec_t;

  localparam int NVEC = 29;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic valid, input logic [7:0] id, input logic en,
                              input logic kill, input logic ack, input logic [7:0] ack_id,
                              input logic e_irq, input logic [7:0] e_id, input logic e_ready,
                              input logic e_kill, input logic e_err);
    vec_t v;
    v.valid = valid; v.id = id; v.en = en; v.kill = kill; v.ack = ack; v.ack_id = ack_id;
    v.e_irq = e_irq; v.e_id = e_id; v.e_ready = e_ready; v.e_kill = e_kill; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    //             valid id     en kill ack ack_id  | irq e_id   rdy kil err
    tbl[0]  = mk(0, 8'h00, 1, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0); // reset state
    tbl[1]  = mk(1, 8'h2A, 1, 0, 0, 8'h00,  0, 8'h00, 0, 0, 0); // offer seen in IDLE
    tbl[2]  = mk(1, 8'h2A, 1, 0, 0, 8'h00,  1, 8'h2A, 0, 0, 0); // request one cycle later
    tbl[3]  = mk(1, 8'h2A, 1, 0, 1, 8'h2A,  1, 8'h2A, 1, 0, 0); // matching ack
    tbl[4]  = mk(0, 8'h00, 1, 0, 0, 8'h00,  0, 8'h2A, 0, 0, 0); // fields held
    tbl[5]  = mk(1, 8'h11, 1, 0, 0, 8'h00,  0, 8'h2A, 0, 0, 0);
    tbl[6]  = mk(1, 8'h11, 1, 1, 0, 8'h00,  1, 8'h11, 0, 1, 0); // kill granted
    tbl[7]  = mk(0, 8'h00, 1, 0, 0, 8'h00,  0, 8'h11, 0, 0, 0);
    tbl[8]  = mk(1, 8'h22, 1, 0, 0, 8'h00,  0, 8'h11, 0, 0, 0);
    tbl[9]  = mk(1, 8'h22, 1, 1, 1, 8'h22,  1, 8'h22, 1, 0, 0); // ack beats kill
    tbl[10] = mk(0, 8'h00, 1, 0, 0, 8'h00,  0, 8'h22, 0, 0, 0);
    tbl[11] = mk(1, 8'h05, 1, 0, 0, 8'h00,  0, 8'h22, 0, 0, 0);
    tbl[12] = mk(1, 8'h09, 1, 0, 0, 8'h00,  1, 8'h05, 0, 0, 0); // retarget to 0x09
    tbl[13] = mk(1, 8'h09, 1, 0, 1, 8'h05,  1, 8'h09, 0, 0, 0); // stale ack id
    tbl[14] = mk(1, 8'h09, 1, 0, 0, 8'h00,  1, 8'h09, 0, 0, 1); // error pulse
    tbl[15] = mk(0, 8'h00, 1, 0, 1, 8'h09,  1, 8'h09, 0, 0, 0); // withdraw + ack
    tbl[16] = mk(0, 8'h00, 1, 0, 0, 8'h00,  0, 8'h09, 0, 0, 1);
    tbl[17] = mk(1, 8'h33, 1, 0, 0, 8'h00,  0, 8'h09, 0, 0, 0);
    tbl[18] = mk(1, 8'h33, 0, 0, 0, 8'h00,  0, 8'h33, 0, 0, 0); // gated
    tbl[19] = mk(1, 8'h33, 0, 0, 0, 8'h00,  0, 8'h33, 0, 0, 0); // still pending
    tbl[20] = mk(1, 8'h33, 1, 0, 0, 8'h00,  1, 8'h33, 0, 0, 0); // ungated
    tbl[21] = mk(1, 8'h33, 0, 1, 0, 8'h00,  0, 8'h33, 0, 1, 0); // kill while gated
    tbl[22] = mk(0, 8'h00, 1, 0, 0, 8'h00,  0, 8'h33, 0, 0, 0);
    tbl[23] = mk(0, 8'h00, 1, 0, 1, 8'h33,  0, 8'h33, 0, 0, 0); // ack in IDLE
    tbl[24] = mk(0, 8'h00, 1, 0, 0, 8'h00,  0, 8'h33, 0, 0, 1);
    tbl[25] = mk(1, 8'h44, 1, 0, 0, 8'h00,  0, 8'h33, 0, 0, 0);
    tbl[26] = mk(1, 8'h44, 1, 0, 1, 8'h44,  1, 8'h44, 1, 0, 0);
    tbl[27] = mk(1, 8'h55, 1, 0, 0, 8'h00,  0, 8'h44, 0, 0, 0); // back-to-back
    tbl[28] = mk(1, 8'h55, 1, 0, 0, 8'h00,  1, 8'h55, 0, 0, 0);
  end

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 8'h00);
    model_reset();
    #2;
    check("reset core_irq", core_irq, 0);
    check("reset ready",    irq_ready, 0);
    check("reset kill_ack", irq_kill_ack, 0);
    check("reset ack_err",  ack_err, 0);
    check("reset id",       core_irq_id, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].valid, tbl[i].id, tbl[i].en, tbl[i].kill, tbl[i].ack, tbl[i].ack_id);
      @(negedge clk);
      check({tag, " core_irq"}, core_irq,       tbl[i].e_irq);
      check({tag, " id"},       core_irq_id,    tbl[i].e_id);
      check({tag, " level"},    core_irq_level, lvl_of(tbl[i].e_id));
      check({tag, " mode"},     core_irq_mode,  mode_of(tbl[i].e_id));
      check({tag, " vsid"},     core_irq_vsid,  vsid_of(tbl[i].e_id));
      check({tag, " v"},        core_irq_v,     v_of(tbl[i].e_id));
      check({tag, " shv"},      core_irq_shv,   shv_of(tbl[i].e_id));
      check({tag, " ready"},    irq_ready,      tbl[i].e_ready);
      check({tag, " kill_ack"}, irq_kill_ack,   tbl[i].e_kill);
      check({tag, " ack_err"},  ack_err,        tbl[i].e_err);
      @(posedge clk);
      model_step();
      #1;
    end

    // Asynchronous reset while an offer is pending and an ack is on the bus
    drive(1, 8'h55, 1, 1, 1, 8'h55);
    #2;
    check("pre-reset core_irq", core_irq, 1);
    check("pre-reset ready",    irq_ready, 1);
    rst = 1'b1;
    #1;
    check("async rst core_irq", core_irq, 0);
    check("async rst ready",    irq_ready, 0);
    check("async rst kill_ack", irq_kill_ack, 0);
    check("async rst ack_err",  ack_err, 0);
    check("async rst id",       core_irq_id, 0);
    @(negedge clk);
    drive(0, 8'h00, 1, 0, 0, 8'h00);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Random traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      logic [7:0] aid;
      irq_valid    = ($urandom_range(0, 99) < 80);
      irq_id       = 8'($urandom_range(0, 15));
      irq_max      = 8'($urandom);
      irq_mode     = 2'($urandom);
      irq_vsid     = 6'($urandom);
      irq_v        = 1'($urandom);
      irq_shv      = 1'($urandom);
      irq_en       = ($urandom_range(0, 99) < 85);
      irq_kill_req = ($urandom_range(0, 99) < 12);
      core_ack     = ($urandom_range(0, 99) < 25);
      aid          = 8'($urandom_range(0, 15));
      core_ack_id  = ($urandom_range(0, 99) < 70) ? m_shown.id : aid;
      @(negedge clk);
      check_model($sformatf("rnd%0d", c));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
